axi_read_responder: RTL
=======================

# axi_read_responder

Memory-backed AXI4 read-channel responder: the slave end of the AR/R burst interface that the instruction cache drives on a miss. It accepts one read address at a time and returns the requested burst of 64-bit beats from an internal word array. It serves as the fetch-side memory model in the processor testbench and as the on-chip boot ROM. A side load port preloads or patches the array.

## Interface
- `addr_width`, 64: AXI address width.
- `mem_words`, 4096: number of 64-bit words in the array; byte span is `mem_words*8`.
- `read_latency`, 4: cycles from AR handshake to first `m_axi_rvalid`; legal range 1–15.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `m_axi_arvalid` in 1: read address valid.
- `m_axi_arready` out 1: responder can accept an address.
- `m_axi_araddr` in `addr_width`: byte address of the first beat.
- `m_axi_arlen` in 8: beats minus one; legal 0–15.
- `m_axi_arsize` in 3: beat size code; only 3 (8 bytes) is supported.
- `m_axi_arburst` in 2: 0 FIXED, 1 INCR, 2 WRAP.
- `m_axi_rvalid` out 1: read data valid.
- `m_axi_rready` in 1: initiator accepts the beat.
- `m_axi_rdata` out 64: beat data.
- `m_axi_rresp` out 2: 0 OKAY, 2 SLVERR, 3 DECERR.
- `m_axi_rlast` out 1: final beat of the burst.
- `load_enable` in 1: write one array word this cycle.
- `load_addr` in `$clog2(mem_words)`: word index to write.
- `load_data` in 64: word to write.

## Operation
- The state machine has three states: IDLE, LATENCY, BURST.
- **IDLE:** `m_axi_arready`=1. On `m_axi_arvalid && m_axi_arready`, the block captures the address, length, size and burst type, and `m_axi_arready` goes to 0 on the next cycle.
- On capture, the latency counter loads `read_latency-1`.
  - If `read_latency`=1, the block goes straight to BURST.
  - Otherwise it goes to LATENCY.
- **LATENCY:** the counter decrements each cycle. At 0, the block goes to BURST with the first beat registered.
- **BURST:** `m_axi_rvalid`=1.
  - The beat counter starts at `m_axi_arlen`. `m_axi_rlast`=1 when the counter is 0.
  - On `m_axi_rvalid && m_axi_rready`, the block advances the address, decrements the counter and registers the next beat.
  - When the last beat is accepted, the block returns to IDLE.
- Word index for each beat is `addr[3 +: $clog2(mem_words)]`. Address bits [2:0] are ignored.
- Next-address rules:
  - FIXED: the address is unchanged.
  - INCR: address + 8.
  - WRAP: address + 8 within an aligned window of `(arlen+1)*8` bytes. Low bits wrap and high bits are held.
- Response codes, fixed per burst at capture:
  - `m_axi_arsize`≠3 gives SLVERR on every beat.
  - Burst type 3 gives SLVERR on every beat.
  - WRAP with `arlen` not in {1,3,7,15} gives SLVERR on every beat.
  - `m_axi_arlen`>15 gives SLVERR; the beat count is still honoured, with `arlen+1` beats sent.
- Per-beat response: if the beat address is ≥ `mem_words*8`, that beat returns DECERR with `m_axi_rdata`=0. Otherwise it returns OKAY with array data, unless the burst-level SLVERR applies.
- Whenever `m_axi_rresp`≠OKAY, `m_axi_rdata` is 0.
- **Load port:** writes take effect at the clock edge and are accepted in every state.
  - A load and a beat fetch to the same word in the same cycle: the beat gets the old data.
  - Beats registered after the write see the new data.

## Timing
- With the AR handshake at cycle T, the first `m_axi_rvalid`=1 is in cycle T+`read_latency`.
- With no stalls, beat k (k from 0) is presented in cycle T+`read_latency`+k. A full 16-beat burst spans `read_latency`+16 cycles.
- `m_axi_rvalid`, `m_axi_rdata`, `m_axi_rresp` and `m_axi_rlast` are registered and held stable while `m_axi_rready`=0.
- After the last beat handshake at cycle L:
  - `m_axi_rvalid`=0 and `m_axi_arready`=1 in cycle L+1.
  - A new AR handshake is possible in L+1.
- `m_axi_arready` is 0 throughout LATENCY and BURST. There is exactly one outstanding burst.
- `m_axi_rready` asserted before `m_axi_rvalid` has no effect.
- Reset is asynchronous and active-low. While `reset`=0:
  - `m_axi_arready`=0, `m_axi_rvalid`=0, `m_axi_rlast`=0, `m_axi_rresp`=0, `m_axi_rdata`=0.
  - The state is IDLE and both counters are 0.
  - `m_axi_arready` rises in the first cycle after `reset` deasserts.
- Reset in mid-burst abandons the burst with no further beats. Array contents are not reset.

## Structure
- The shared package `axi_pkg` holds:
  - burst-type enum (FIXED/INCR/WRAP);
  - response-code constants (OKAY/SLVERR/DECERR);
  - responder state enum;
  - `AXI_BEAT_BYTES`=8 and `AXI_MAX_LEN`=15.
- The sub-module `axi_burst_addr_gen` is combinational. Inputs: current address, length, burst type. Output: next address. The cache-side initiator reuses it.

## Test plan
- Preload words 0–7 with 0x1000+i. INCR burst, `araddr`=0x0, `arlen`=7, `rready`=1 -> eight beats 0x1000..0x1007, first `rvalid` at T+4, `rlast` only on beat 7, all OKAY.
- WRAP burst, `araddr`=0x28, `arlen`=7 -> word order 5,6,7,0,1,2,3,4, with `rlast` on word 4.
- Same INCR burst with `rready` toggling 1,0,0,1… -> data/resp/last held during stalls, no beat lost or duplicated, `arready` stays 0 until the cycle after the final handshake.
- `araddr`=`mem_words*8`-16, `arlen`=3 -> beats 0–1 OKAY with data, beats 2–3 DECERR with `rdata`=0. A second burst with `arsize`=2 -> all beats SLVERR.
- Pull `reset` low during beat 2 of 8 -> `rvalid` drops immediately. After release, `arready`=1 next cycle, and a new burst returns correct data.
- Issue `load_enable` to word 3 with 0xDEAD on the same cycle beat 3 is registered -> the beat returns the old value, and a later burst returns 0xDEAD.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 read-channel definitions: burst types, response codes, responder
// states and the burst-level error rule used at address capture.
package axi_pkg;

  localparam int AXI_BEAT_BYTES = 8;
  localparam int AXI_MAX_LEN    = 15;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATENCY,
    ST_BURST
  } state_e;

  // Burst-wide SLVERR: unsupported size, reserved burst type, bad wrap length, or over-long burst.
  function automatic logic burst_slverr(input logic [2:0] size,
                                        input logic [1:0] burst,
                                        input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size != 3'd3) || (burst == 2'd3) ||
           ((burst == BURST_WRAP) && !wrap_len_ok) ||
           (len > 8'(AXI_MAX_LEN));
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address for FIXED, INCR and WRAP bursts.
// Reserved burst type 3 advances like INCR.
module axi_burst_addr_gen #(
  parameter int addr_width = 64
) (
  input  logic [addr_width-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [1:0]            burst_i,
  output logic [addr_width-1:0] next_addr_o
);
  import axi_pkg::*;

  logic [addr_width-1:0] incr_addr;
  logic [addr_width-1:0] wrap_mask;

  always_comb begin
    incr_addr = addr_i + addr_width'(AXI_BEAT_BYTES);
    // For legal wrap lengths (1,3,7,15) this is exactly the window size minus one.
    wrap_mask = addr_width'({len_i, 3'b111});
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr_o = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_read_responder.sv
// Memory-backed AXI4 read responder: one outstanding AR, fixed latency to the
// first beat, registered R outputs, plus a side port for loading the word array.
module axi_read_responder #(
  parameter int addr_width   = 64,
  parameter int mem_words    = 4096,
  parameter int read_latency = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         m_axi_arvalid,
  output logic                         m_axi_arready,
  input  logic [addr_width-1:0]        m_axi_araddr,
  input  logic [7:0]                   m_axi_arlen,
  input  logic [2:0]                   m_axi_arsize,
  input  logic [1:0]                   m_axi_arburst,
  output logic                         m_axi_rvalid,
  input  logic                         m_axi_rready,
  output logic [63:0]                  m_axi_rdata,
  output logic [1:0]                   m_axi_rresp,
  output logic                         m_axi_rlast,
  input  logic                         load_enable,
  input  logic [$clog2(mem_words)-1:0] load_addr,
  input  logic [63:0]                  load_data
);
  import axi_pkg::*;

  localparam int                    IDX_W     = $clog2(mem_words);
  localparam logic [addr_width-1:0] MEM_BYTES = addr_width'(mem_words * AXI_BEAT_BYTES);
  localparam logic [3:0]            LAT_INIT  = 4'(read_latency - 1);

  state_e                state_q, state_d;
  logic [3:0]            lat_cnt_q, lat_cnt_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [7:0]            len_q, len_d;
  logic [1:0]            burst_q, burst_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic                  slverr_q, slverr_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  arready_q, arready_d;
  logic [addr_width-1:0] next_addr;
  logic                  fetch_en;
  logic [addr_width-1:0] fetch_addr;
  logic [63:0]           mem [mem_words];
  logic [63:0]           mem_rd_q;

  function automatic logic [1:0] beat_resp(input logic [addr_width-1:0] a, input logic err);
    if (a >= MEM_BYTES) return RESP_DECERR;
    if (err)            return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  axi_burst_addr_gen #(.addr_width(addr_width)) u_addr_gen (
    .addr_i      (addr_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    burst_d    = burst_q;
    addr_d     = addr_q;
    slverr_d   = slverr_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rresp_d    = rresp_q;
    fetch_en   = 1'b0;
    fetch_addr = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m_axi_arvalid && arready_q) begin
          addr_d     = m_axi_araddr;
          len_d      = m_axi_arlen;
          burst_d    = m_axi_arburst;
          slverr_d   = burst_slverr(m_axi_arsize, m_axi_arburst, m_axi_arlen);
          lat_cnt_d  = LAT_INIT;
          beat_cnt_d = m_axi_arlen;
          if (read_latency == 1) begin
            state_d    = ST_BURST;
            fetch_en   = 1'b1;
            fetch_addr = m_axi_araddr;
            rvalid_d   = 1'b1;
            rlast_d    = (m_axi_arlen == 8'd0);
            rresp_d    = beat_resp(m_axi_araddr, slverr_d);
          end else begin
            state_d = ST_LATENCY;
          end
        end
      end
      ST_LATENCY: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        if (lat_cnt_q <= 4'd1) begin
          state_d    = ST_BURST;
          fetch_en   = 1'b1;
          fetch_addr = addr_q;
          rvalid_d   = 1'b1;
          rlast_d    = (beat_cnt_q == 8'd0);
          rresp_d    = beat_resp(addr_q, slverr_q);
        end
      end
      ST_BURST: begin
        if (m_axi_rready) begin
          if (beat_cnt_q == 8'd0) begin
            state_d  = ST_IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            rresp_d  = RESP_OKAY;
          end else begin
            addr_d     = next_addr;
            beat_cnt_d = beat_cnt_q - 8'd1;
            fetch_en   = 1'b1;
            fetch_addr = next_addr;
            rlast_d    = (beat_cnt_q == 8'd1);
            rresp_d    = beat_resp(next_addr, slverr_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    arready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      lat_cnt_q  <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      burst_q    <= '0;
      addr_q     <= '0;
      slverr_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= RESP_OKAY;
      arready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      addr_q     <= addr_d;
      slverr_q   <= slverr_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rresp_q    <= rresp_d;
      arready_q  <= arready_d;
    end
  end

  // Array is never reset; a same-cycle load and fetch of one word returns the old value.
  always_ff @(posedge clock) begin
    if (load_enable) mem[load_addr] <= load_data;
    if (fetch_en)    mem_rd_q <= mem[fetch_addr[3 +: IDX_W]];
  end

  assign m_axi_arready = arready_q;
  assign m_axi_rvalid  = rvalid_q;
  assign m_axi_rlast   = rlast_q;
  assign m_axi_rresp   = rresp_q;
  assign m_axi_rdata   = (rvalid_q && (rresp_q == RESP_OKAY)) ? mem_rd_q : 64'd0;

endmodule
